// File: rtl/mem_access_stage_pkg.sv
// Shared constants and FSM encoding for the MEM pipeline stage.
// Element widths, default lane count and writeback-enable bit positions live here.
package mem_access_stage_pkg;

    localparam int INT8   = 8;
    localparam int INT32  = 32;
    localparam int LENGTH = 16;

    localparam int WB_S = 0;
    localparam int WB_V = 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/mem_access_stage_mem_req_ctrl.sv
// Data-memory request controller: IDLE/BUSY FSM plus the registers that hold
// the request stable on the memory port until it is acknowledged.
module mem_access_stage_mem_req_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    input  logic              i_mem,
    input  logic              i_we,
    input  logic              i_vec,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_ack,
    output logic              o_ready,
    output logic              o_launch,
    output logic              o_done,
    output logic              o_req,
    output logic              o_we,
    output logic              o_vec,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_wdata
);
    import mem_access_stage_pkg::*;

    state_t r_state;
    state_t w_next;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // NOTE: every combinational output is defaulted first so no path can infer a latch.
    always_comb begin
        w_next   = r_state;
        o_ready  = 1'b0;
        o_launch = 1'b0;
        o_done   = 1'b0;
        case (r_state)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid && i_mem) begin
                    o_launch = 1'b1;
                    w_next   = BUSY;
                end
            end
            BUSY: begin
                if (i_ack) begin
                    o_done = 1'b1;
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // The request is a pure function of the state flop, so async reset drops it at once.
    assign o_req = (r_state == BUSY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_we    <= 1'b0;
            o_vec   <= 1'b0;
            o_addr  <= '0;
            o_wdata <= '0;
        end else if (o_launch) begin
            o_we    <= i_we;
            o_vec   <= i_vec;
            o_addr  <= i_addr;
            o_wdata <= i_wdata;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: scalar/vector load/store over a req/ack port, stalling EX
// while an access is outstanding, and registering everything writeback consumes.
module mem_access_stage #(
    parameter int LENGTH = mem_access_stage_pkg::LENGTH,
    parameter int ADDR_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic [4:0]            ex_rD,
    input  logic [31:0]           ex_s_result,
    input  logic [LENGTH*8-1:0]   ex_v_result,
    input  logic [ADDR_W-1:0]     ex_addr,
    input  logic [31:0]           ex_s_wdata,
    input  logic [LENGTH*8-1:0]   ex_v_wdata,
    input  logic                  ex_ldr,
    input  logic                  ex_str,
    input  logic                  ex_vec,
    input  logic [1:0]            ex_wb,
    input  logic [LENGTH*8-1:0]   ex_conv_result,
    input  logic [4:0]            ex_conv_addr,
    input  logic                  ex_conv_write,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic                  mem_vec,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [LENGTH*8-1:0]   mem_wdata,
    input  logic                  mem_ack,
    input  logic [LENGTH*8-1:0]   mem_rdata,
    output logic [4:0]            wb_rD,
    output logic [31:0]           wb_s_result,
    output logic [LENGTH*8-1:0]   wb_v_result,
    output logic [31:0]           wb_smem,
    output logic [LENGTH*8-1:0]   wb_vmem,
    output logic                  wb_ldr,
    output logic [1:0]            wb_wb,
    output logic [LENGTH*8-1:0]   wb_conv_result,
    output logic [4:0]            wb_conv_addr,
    output logic                  wb_conv_write
);
    import mem_access_stage_pkg::*;

    localparam int VW = LENGTH * INT8;

    logic          w_is_mem;
    logic          w_we;
    logic [VW-1:0] w_wdata;
    logic          w_launch;
    logic          w_done;

    // A simultaneous ldr+str is illegal and resolves to a load.
    assign w_is_mem = ex_ldr | ex_str;
    assign w_we     = ex_str & ~ex_ldr;
    assign w_wdata  = ex_vec ? ex_v_wdata : {{(VW-INT32){1'b0}}, ex_s_wdata};

    mem_access_stage_mem_req_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (VW)
    ) u_req_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_valid  (ex_valid),
        .i_mem    (w_is_mem),
        .i_we     (w_we),
        .i_vec    (ex_vec),
        .i_addr   (ex_addr),
        .i_wdata  (w_wdata),
        .i_ack    (mem_ack),
        .o_ready  (ex_ready),
        .o_launch (w_launch),
        .o_done   (w_done),
        .o_req    (mem_req),
        .o_we     (mem_we),
        .o_vec    (mem_vec),
        .o_addr   (mem_addr),
        .o_wdata  (mem_wdata)
    );

    logic [4:0]    r_op_rD;
    logic [31:0]   r_op_s_result;
    logic [VW-1:0] r_op_v_result;
    logic          r_op_ldr;
    logic          r_op_vec;
    logic [1:0]    r_op_wb;
    logic [VW-1:0] r_op_conv_result;
    logic [4:0]    r_op_conv_addr;
    logic          r_op_conv_write;

    // NOTE: the held op is reset too, so an access aborted by reset leaves nothing to replay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_rD          <= '0;
            r_op_s_result    <= '0;
            r_op_v_result    <= '0;
            r_op_ldr         <= 1'b0;
            r_op_vec         <= 1'b0;
            r_op_wb          <= '0;
            r_op_conv_result <= '0;
            r_op_conv_addr   <= '0;
            r_op_conv_write  <= 1'b0;
        end else if (w_launch) begin
            r_op_rD          <= ex_rD;
            r_op_s_result    <= ex_s_result;
            r_op_v_result    <= ex_v_result;
            r_op_ldr         <= ex_ldr;
            r_op_vec         <= ex_vec;
            r_op_wb          <= ex_wb;
            r_op_conv_result <= ex_conv_result;
            r_op_conv_addr   <= ex_conv_addr;
            r_op_conv_write  <= ex_conv_write;
        end
    end

    // Launch, waiting and idle cycles all fall to the bubble branch; only write enables clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_rD          <= '0;
            wb_s_result    <= '0;
            wb_v_result    <= '0;
            wb_smem        <= '0;
            wb_vmem        <= '0;
            wb_ldr         <= 1'b0;
            wb_wb          <= '0;
            wb_conv_result <= '0;
            wb_conv_addr   <= '0;
            wb_conv_write  <= 1'b0;
        end else if (w_done) begin
            wb_rD          <= r_op_rD;
            wb_s_result    <= r_op_s_result;
            wb_v_result    <= r_op_v_result;
            wb_smem        <= (r_op_ldr && !r_op_vec) ? mem_rdata[INT32-1:0] : '0;
            wb_vmem        <= (r_op_ldr &&  r_op_vec) ? mem_rdata : '0;
            wb_ldr         <= r_op_ldr;
            wb_wb          <= r_op_ldr ? r_op_wb : 2'b00;
            wb_conv_result <= r_op_conv_result;
            wb_conv_addr   <= r_op_conv_addr;
            wb_conv_write  <= r_op_conv_write;
        end else if (ex_ready && ex_valid && !w_is_mem) begin
            wb_rD          <= ex_rD;
            wb_s_result    <= ex_s_result;
            wb_v_result    <= ex_v_result;
            wb_smem        <= '0;
            wb_vmem        <= '0;
            wb_ldr         <= ex_ldr;
            wb_wb          <= ex_wb;
            wb_conv_result <= ex_conv_result;
            wb_conv_addr   <= ex_conv_addr;
            wb_conv_write  <= ex_conv_write;
        end else begin
            wb_wb[WB_S]    <= 1'b0;
            wb_wb[WB_V]    <= 1'b0;
            wb_conv_write  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage: ALU pass-through, scalar and
// vector memory ops, back-to-back loads, conv sideband and asynchronous reset.
module tb_mem_access_stage;

    localparam int LENGTH = 16;
    localparam int ADDR_W = 16;
    localparam int VW     = LENGTH * 8;
    localparam int ALLW   = 5 + 32 + VW + 32 + VW + 1 + 2 + VW + 5 + 1;

    logic              clk;
    logic              rst_n;
    logic              ex_valid;
    logic              ex_ready;
    logic [4:0]        ex_rD;
    logic [31:0]       ex_s_result;
    logic [VW-1:0]     ex_v_result;
    logic [ADDR_W-1:0] ex_addr;
    logic [31:0]       ex_s_wdata;
    logic [VW-1:0]     ex_v_wdata;
    logic              ex_ldr;
    logic              ex_str;
    logic              ex_vec;
    logic [1:0]        ex_wb;
    logic [VW-1:0]     ex_conv_result;
    logic [4:0]        ex_conv_addr;
    logic              ex_conv_write;
    logic              mem_req;
    logic              mem_we;
    logic              mem_vec;
    logic [ADDR_W-1:0] mem_addr;
    logic [VW-1:0]     mem_wdata;
    logic              mem_ack;
    logic [VW-1:0]     mem_rdata;
    logic [4:0]        wb_rD;
    logic [31:0]       wb_s_result;
    logic [VW-1:0]     wb_v_result;
    logic [31:0]       wb_smem;
    logic [VW-1:0]     wb_vmem;
    logic              wb_ldr;
    logic [1:0]        wb_wb;
    logic [VW-1:0]     wb_conv_result;
    logic [4:0]        wb_conv_addr;
    logic              wb_conv_write;

    int checks   = 0;
    int failures = 0;

    mem_access_stage #(
        .LENGTH (LENGTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_valid       (ex_valid),
        .ex_ready       (ex_ready),
        .ex_rD          (ex_rD),
        .ex_s_result    (ex_s_result),
        .ex_v_result    (ex_v_result),
        .ex_addr        (ex_addr),
        .ex_s_wdata     (ex_s_wdata),
        .ex_v_wdata     (ex_v_wdata),
        .ex_ldr         (ex_ldr),
        .ex_str         (ex_str),
        .ex_vec         (ex_vec),
        .ex_wb          (ex_wb),
        .ex_conv_result (ex_conv_result),
        .ex_conv_addr   (ex_conv_addr),
        .ex_conv_write  (ex_conv_write),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_vec        (mem_vec),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .wb_rD          (wb_rD),
        .wb_s_result    (wb_s_result),
        .wb_v_result    (wb_v_result),
        .wb_smem        (wb_smem),
        .wb_vmem        (wb_vmem),
        .wb_ldr         (wb_ldr),
        .wb_wb          (wb_wb),
        .wb_conv_result (wb_conv_result),
        .wb_conv_addr   (wb_conv_addr),
        .wb_conv_write  (wb_conv_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_valid       = 1'b0;
        ex_rD          = '0;
        ex_s_result    = '0;
        ex_v_result    = '0;
        ex_addr        = '0;
        ex_s_wdata     = '0;
        ex_v_wdata     = '0;
        ex_ldr         = 1'b0;
        ex_str         = 1'b0;
        ex_vec         = 1'b0;
        ex_wb          = '0;
        ex_conv_result = '0;
        ex_conv_addr   = '0;
        ex_conv_write  = 1'b0;
        mem_ack        = 1'b0;
        mem_rdata      = '0;
    endtask

    task automatic test_reset();
        logic [ALLW-1:0] all_wb;
        rst_n = 1'b0;
        idle_inputs();
        #12;
        all_wb = {wb_rD, wb_s_result, wb_v_result, wb_smem, wb_vmem, wb_ldr, wb_wb,
                  wb_conv_result, wb_conv_addr, wb_conv_write};
        checks++;
        if (all_wb !== '0) begin
            failures++;
            $display("FAIL reset_wb got=%h exp=0", all_wb);
        end
        checks++;
        if ({mem_req, mem_we, mem_vec, mem_addr, mem_wdata} !== '0) begin
            failures++;
            $display("FAIL reset_mem req=%b we=%b vec=%b addr=%h exp all 0", mem_req, mem_we, mem_vec, mem_addr);
        end
        checks++;
        if (ex_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=1", ex_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_alu_op();
        idle_inputs();
        ex_valid    = 1'b1;
        ex_wb       = 2'b01;
        ex_rD       = 5'd3;
        ex_s_result = 32'h1234;
        ex_v_result = {8{16'hBEEF}};
        checks++;
        if (ex_ready !== 1'b1) begin
            failures++;
            $display("FAIL alu_ready_pre got=%b exp=1", ex_ready);
        end
        tick();
        ex_valid = 1'b0;
        checks++;
        if (wb_s_result !== 32'h1234) begin
            failures++;
            $display("FAIL alu_s_result got=%h exp=%h", wb_s_result, 32'h1234);
        end
        checks++;
        if (wb_wb !== 2'b01 || wb_rD !== 5'd3) begin
            failures++;
            $display("FAIL alu_wb got wb=%b rD=%0d exp wb=01 rD=3", wb_wb, wb_rD);
        end
        checks++;
        if (wb_v_result !== {8{16'hBEEF}} || wb_smem !== 32'h0 || wb_ldr !== 1'b0) begin
            failures++;
            $display("FAIL alu_fields got v=%h smem=%h ldr=%b", wb_v_result, wb_smem, wb_ldr);
        end
        checks++;
        if (ex_ready !== 1'b1 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL alu_no_stall got ready=%b req=%b exp 1/0", ex_ready, mem_req);
        end
        tick();
        checks++;
        if (wb_wb !== 2'b00 || wb_s_result !== 32'h1234) begin
            failures++;
            $display("FAIL alu_bubble got wb=%b s=%h exp wb=00 s=1234", wb_wb, wb_s_result);
        end
    endtask

    task automatic test_scalar_load();
        int req_cnt = 0;
        int wr_cnt  = 0;
        idle_inputs();
        ex_valid = 1'b1;
        ex_ldr   = 1'b1;
        ex_addr  = 16'h0040;
        ex_rD    = 5'd5;
        ex_wb    = 2'b01;
        tick();
        ex_valid = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_vec !== 1'b0 || mem_addr !== 16'h0040) begin
            failures++;
            $display("FAIL sload_req got req=%b we=%b vec=%b addr=%h exp 1/0/0/0040", mem_req, mem_we, mem_vec, mem_addr);
        end
        checks++;
        if (ex_ready !== 1'b0 || wb_wb !== 2'b00) begin
            failures++;
            $display("FAIL sload_launch got ready=%b wb=%b exp 0/00", ex_ready, wb_wb);
        end
        for (int i = 0; i < 8; i++) begin
            if (mem_req) req_cnt++;
            mem_ack   = mem_req && (req_cnt == 3);
            mem_rdata = {32'h11111111, 32'h22222222, 32'h33333333, 32'hDEADBEEF};
            tick();
            mem_ack = 1'b0;
            if (wb_wb == 2'b01) begin
                wr_cnt++;
                checks++;
                if (wb_smem !== 32'hDEADBEEF || wb_vmem !== '0 || wb_ldr !== 1'b1 || wb_rD !== 5'd5) begin
                    failures++;
                    $display("FAIL sload_data got smem=%h ldr=%b rD=%0d exp DEADBEEF/1/5", wb_smem, wb_ldr, wb_rD);
                end
            end
        end
        checks++;
        if (req_cnt != 3) begin
            failures++;
            $display("FAIL sload_req_cycles got=%0d exp=3", req_cnt);
        end
        checks++;
        if (wr_cnt != 1) begin
            failures++;
            $display("FAIL sload_write_once got=%0d exp=1", wr_cnt);
        end
    endtask

    task automatic test_vector_store();
        idle_inputs();
        ex_valid   = 1'b1;
        ex_str     = 1'b1;
        ex_vec     = 1'b1;
        ex_addr    = 16'h0080;
        ex_v_wdata = {16{8'hA5}};
        ex_s_wdata = 32'h77777777;
        ex_rD      = 5'd9;
        ex_wb      = 2'b10;
        tick();
        ex_valid = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_vec !== 1'b1 || mem_addr !== 16'h0080) begin
            failures++;
            $display("FAIL vstore_req got req=%b we=%b vec=%b addr=%h exp 1/1/1/0080", mem_req, mem_we, mem_vec, mem_addr);
        end
        checks++;
        if (mem_wdata !== {16{8'hA5}}) begin
            failures++;
            $display("FAIL vstore_wdata got=%h exp=all A5", mem_wdata);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        checks++;
        if (wb_wb !== 2'b00 || wb_ldr !== 1'b0 || wb_rD !== 5'd9) begin
            failures++;
            $display("FAIL vstore_wb got wb=%b ldr=%b rD=%0d exp 00/0/9", wb_wb, wb_ldr, wb_rD);
        end
        checks++;
        if (mem_req !== 1'b0 || ex_ready !== 1'b1) begin
            failures++;
            $display("FAIL vstore_release got req=%b ready=%b exp 0/1", mem_req, ex_ready);
        end
    endtask

    task automatic test_back_to_back();
        int idx     = 0;
        int req_n   = 0;
        int cnt_a   = 0;
        int cnt_b   = 0;
        int req_cyc [4];
        logic accepted;
        idle_inputs();
        for (int k = 0; k < 4; k++) req_cyc[k] = -1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (mem_req) begin
                if (req_n < 4) req_cyc[req_n] = cyc;
                req_n++;
            end
            if (wb_wb == 2'b01) begin
                if (wb_rD == 5'd10) begin
                    cnt_a++;
                    checks++;
                    if (wb_smem !== 32'hC0DE0100) begin
                        failures++;
                        $display("FAIL b2b_data_a got=%h exp=C0DE0100", wb_smem);
                    end
                end else if (wb_rD == 5'd11) begin
                    cnt_b++;
                    checks++;
                    if (wb_smem !== 32'hC0DE0104) begin
                        failures++;
                        $display("FAIL b2b_data_b got=%h exp=C0DE0104", wb_smem);
                    end
                end
            end
            if (idx < 2) begin
                ex_valid = 1'b1;
                ex_ldr   = 1'b1;
                ex_wb    = 2'b01;
                ex_rD    = 5'(10 + idx);
                ex_addr  = 16'(16'h0100 + 4 * idx);
            end else begin
                ex_valid = 1'b0;
                ex_ldr   = 1'b0;
            end
            mem_ack   = mem_req;
            mem_rdata = {{(VW-32){1'b0}}, 16'hC0DE, mem_addr};
            accepted  = ex_valid && ex_ready;
            tick();
            if (accepted) idx++;
        end
        mem_ack = 1'b0;
        checks++;
        if (req_n != 2 || req_cyc[0] != 1 || req_cyc[1] != 3) begin
            failures++;
            $display("FAIL b2b_req_spacing got n=%0d c0=%0d c1=%0d exp n=2 c0=1 c1=3", req_n, req_cyc[0], req_cyc[1]);
        end
        checks++;
        if (cnt_a != 1 || cnt_b != 1) begin
            failures++;
            $display("FAIL b2b_write_once got a=%0d b=%0d exp 1/1", cnt_a, cnt_b);
        end
    endtask

    task automatic test_conv_with_load();
        int req_cnt = 0;
        int pulses  = 0;
        idle_inputs();
        ex_valid       = 1'b1;
        ex_ldr         = 1'b1;
        ex_vec         = 1'b1;
        ex_addr        = 16'h0200;
        ex_rD          = 5'd12;
        ex_wb          = 2'b10;
        ex_conv_write  = 1'b1;
        ex_conv_addr   = 5'd7;
        ex_conv_result = {16{8'h3C}};
        tick();
        idle_inputs();
        checks++;
        if (wb_conv_write !== 1'b0 || mem_vec !== 1'b1) begin
            failures++;
            $display("FAIL conv_launch got conv_write=%b vec=%b exp 0/1", wb_conv_write, mem_vec);
        end
        for (int i = 0; i < 8; i++) begin
            if (mem_req) req_cnt++;
            mem_ack   = mem_req && (req_cnt == 2);
            mem_rdata = {4{32'hCAFEF00D}};
            tick();
            mem_ack = 1'b0;
            if (wb_conv_write) begin
                pulses++;
                checks++;
                if (wb_conv_addr !== 5'd7 || wb_conv_result !== {16{8'h3C}} || wb_wb !== 2'b10 ||
                    wb_vmem !== {4{32'hCAFEF00D}} || wb_smem !== 32'h0 || wb_rD !== 5'd12) begin
                    failures++;
                    $display("FAIL conv_data got caddr=%0d wb=%b vmem=%h smem=%h rD=%0d", wb_conv_addr, wb_wb, wb_vmem, wb_smem, wb_rD);
                end
            end
        end
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL conv_pulse_once got=%0d exp=1", pulses);
        end
    endtask

    task automatic test_reset_mid_access();
        logic [ALLW-1:0] all_wb;
        idle_inputs();
        ex_valid = 1'b1;
        ex_ldr   = 1'b1;
        ex_addr  = 16'h0300;
        ex_rD    = 5'd20;
        ex_wb    = 2'b01;
        tick();
        ex_valid = 1'b0;
        ex_ldr   = 1'b0;
        checks++;
        if (mem_req !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_pre got req=%b exp=1", mem_req);
        end
        #2;
        rst_n = 1'b0;
        #1;
        all_wb = {wb_rD, wb_s_result, wb_v_result, wb_smem, wb_vmem, wb_ldr, wb_wb,
                  wb_conv_result, wb_conv_addr, wb_conv_write};
        checks++;
        if (mem_req !== 1'b0 || mem_addr !== '0 || ex_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_async got req=%b addr=%h ready=%b exp 0/0000/1", mem_req, mem_addr, ex_ready);
        end
        checks++;
        if (all_wb !== '0) begin
            failures++;
            $display("FAIL rst_mid_wb got=%h exp=0", all_wb);
        end
        #4;
        rst_n   = 1'b1;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        checks++;
        if (mem_req !== 1'b0 || ex_ready !== 1'b1 || wb_wb !== 2'b00 || wb_rD !== 5'd0) begin
            failures++;
            $display("FAIL rst_mid_after got req=%b ready=%b wb=%b rD=%0d exp 0/1/00/0", mem_req, ex_ready, wb_wb, wb_rD);
        end
    endtask

    initial begin
        test_reset();
        tick();
        test_alu_op();
        test_scalar_load();
        tick();
        test_vector_store();
        tick();
        test_back_to_back();
        tick();
        test_conv_with_load();
        test_reset_mid_access();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
